// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the instruction encoder: the operation-select
// enum, major opcodes, R-type funct codes and the loader FSM state type.
package mips_pkg;

    // Symbolic operation select presented on op_sel. Codes 19..31 are illegal.
    typedef enum logic [4:0] {
        OPS_ADD  = 5'd0,
        OPS_SUB  = 5'd1,
        OPS_AND  = 5'd2,
        OPS_OR   = 5'd3,
        OPS_XOR  = 5'd4,
        OPS_NOR  = 5'd5,
        OPS_SLT  = 5'd6,
        OPS_SLTU = 5'd7,
        OPS_SLL  = 5'd8,
        OPS_SRL  = 5'd9,
        OPS_SRA  = 5'd10,
        OPS_SLLV = 5'd11,
        OPS_SRLV = 5'd12,
        OPS_JR   = 5'd13,
        OPS_ADDI = 5'd14,
        OPS_LW   = 5'd15,
        OPS_SW   = 5'd16,
        OPS_BEQ  = 5'd17,
        OPS_BNE  = 5'd18
    } op_sel_e;

    // Major opcodes, instruction bits [31:26].
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    // R-type funct codes, instruction bits [5:0].
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    // Loader session state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } enc_state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational MIPS word packer: maps op_sel plus raw fields onto a 32-bit
// R-type or I-type instruction, zeroing the fields each operation ignores.
module instr_pack
    import mips_pkg::*;
(
    input  logic [4:0]  op_sel,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    logic       r_type;
    logic       keep_shamt;
    logic       zero_rs;
    logic       is_jr;
    logic [5:0] funct;
    logic [5:0] opcode;
    logic [4:0] rs_f;
    logic [4:0] rt_f;
    logic [4:0] rd_f;
    logic [4:0] sh_f;

    // Decode op_sel into format, opcode/funct and field-forcing flags, then pack.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path through the case can leave one holding its old value and infer a latch.
        illegal    = 1'b0;
        r_type     = 1'b1;
        keep_shamt = 1'b0;
        zero_rs    = 1'b0;
        is_jr      = 1'b0;
        funct      = FN_SLL;
        opcode     = OP_RTYPE;
        word       = '0;
        case (op_sel)
            OPS_ADD:  funct = FN_ADD;
            OPS_SUB:  funct = FN_SUB;
            OPS_AND:  funct = FN_AND;
            OPS_OR:   funct = FN_OR;
            OPS_XOR:  funct = FN_XOR;
            OPS_NOR:  funct = FN_NOR;
            OPS_SLT:  funct = FN_SLT;
            OPS_SLTU: funct = FN_SLTU;
            OPS_SLL:  begin funct = FN_SLL; keep_shamt = 1'b1; zero_rs = 1'b1; end
            OPS_SRL:  begin funct = FN_SRL; keep_shamt = 1'b1; zero_rs = 1'b1; end
            OPS_SRA:  begin funct = FN_SRA; keep_shamt = 1'b1; zero_rs = 1'b1; end
            OPS_SLLV: funct = FN_SLLV;
            OPS_SRLV: funct = FN_SRLV;
            OPS_JR:   begin funct = FN_JR; is_jr = 1'b1; end
            OPS_ADDI: begin r_type = 1'b0; opcode = OP_ADDI; end
            OPS_LW:   begin r_type = 1'b0; opcode = OP_LW;   end
            OPS_SW:   begin r_type = 1'b0; opcode = OP_SW;   end
            OPS_BEQ:  begin r_type = 1'b0; opcode = OP_BEQ;  end
            OPS_BNE:  begin r_type = 1'b0; opcode = OP_BNE;  end
            default:  illegal = 1'b1;
        endcase

        // Immediate shifts take no rs; jr uses rs only; shamt only for shifts.
        rs_f = zero_rs    ? 5'd0 : rs;
        rt_f = is_jr      ? 5'd0 : rt;
        rd_f = is_jr      ? 5'd0 : rd;
        sh_f = keep_shamt ? shamt : 5'd0;

        if (illegal) begin
            word = '0;
        end else if (r_type) begin
            word = {OP_RTYPE, rs_f, rt_f, rd_f, sh_f, funct};
        end else begin
            word = {opcode, rs, rt, imm};
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder and instruction-memory loader. Accepts one symbolic
// instruction per valid/ready handshake, packs it via instr_pack and writes
// it to consecutive addresses through a registered write port.
// Optional feature: define ENC_CHECKSUM_EN to add the running-XOR output chk.
module instr_encoder
    import mips_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          finish,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    op_sel,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic [4:0]    rd,
    input  logic [4:0]    shamt,
    input  logic [15:0]   imm,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          done,
    output logic          err_illegal
`ifdef ENC_CHECKSUM_EN
    ,
    output logic [31:0]   chk
`endif
);

    localparam logic [AW:0] FULL    = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);

    enc_state_e    state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
`ifdef ENC_CHECKSUM_EN
    logic [31:0]   chk_q, chk_d;
`endif

    logic [31:0]   pack_word;
    logic          pack_illegal;
    logic          accept;

    instr_pack u_pack (
        .op_sel  (op_sel),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .shamt   (shamt),
        .imm     (imm),
        .word    (pack_word),
        .illegal (pack_illegal)
    );

    // count doubles as the next write address; it never passes DEPTH.
    assign in_ready = (state_q == ST_LOAD) && (count_q < FULL);
    assign accept   = in_valid && in_ready;

    // Next-state logic: session control, write generation and sticky flags.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = done_q;
        err_d     = err_q;
`ifdef ENC_CHECKSUM_EN
        chk_d     = chk_q;
`endif
        if (start) begin
            // A start in any state opens a fresh session; a write accepted
            // in the same cycle is dropped.
            state_d   = ST_LOAD;
            count_d   = '0;
            wr_addr_d = '0;
            done_d    = 1'b0;
            err_d     = 1'b0;
`ifdef ENC_CHECKSUM_EN
            chk_d     = '0;
`endif
        end else if (state_q == ST_LOAD) begin
            if (accept) begin
                if (pack_illegal) begin
                    err_d = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = count_q[AW-1:0];
                    wr_data_d = pack_word;
                    count_d   = count_q + CNT_ONE;
`ifdef ENC_CHECKSUM_EN
                    chk_d     = chk_q ^ pack_word;
`endif
                end
            end
            // Full is seen one cycle after the final write has been issued.
            if (finish || (count_q == FULL)) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
        end
    end

    // State and output registers; reset aborts any session with no write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef ENC_CHECKSUM_EN
            chk_q     <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values computed in always_comb.
            state_q   <= state_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef ENC_CHECKSUM_EN
            chk_q     <= chk_d;
`endif
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign count       = count_q;
    assign busy        = (state_q == ST_LOAD);
    assign done        = done_q;
    assign err_illegal = err_q;
`ifdef ENC_CHECKSUM_EN
    assign chk         = chk_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder. Two instances share one stimulus stream:
// dut_a at the default DEPTH=64 and dut_b at DEPTH=4 for the full-memory case.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        finish = 1'b0;
    logic        in_valid = 1'b0;
    logic [4:0]  op_sel = '0;
    logic [4:0]  rs = '0;
    logic [4:0]  rt = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  shamt = '0;
    logic [15:0] imm = '0;

    logic        a_in_ready, a_wr_en, a_busy, a_done, a_err;
    logic [5:0]  a_wr_addr;
    logic [31:0] a_wr_data;
    logic [6:0]  a_count;
    logic        b_in_ready, b_wr_en, b_busy, b_done, b_err;
    logic [1:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic [2:0]  b_count;
`ifdef ENC_CHECKSUM_EN
    logic [31:0] a_chk, b_chk;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [49:0] a_all;
    logic [41:0] b_all;
    assign a_all = {a_in_ready, a_wr_en, a_wr_addr, a_wr_data, a_count, a_busy, a_done, a_err};
    assign b_all = {b_in_ready, b_wr_en, b_wr_addr, b_wr_data, b_count, b_busy, b_done, b_err};

    always #5 clk = ~clk;

    instr_encoder dut_a (
        .clk (clk), .rst_n (rst_n), .start (start), .finish (finish),
        .in_valid (in_valid), .in_ready (a_in_ready),
        .op_sel (op_sel), .rs (rs), .rt (rt), .rd (rd), .shamt (shamt), .imm (imm),
        .wr_en (a_wr_en), .wr_addr (a_wr_addr), .wr_data (a_wr_data),
        .count (a_count), .busy (a_busy), .done (a_done), .err_illegal (a_err)
`ifdef ENC_CHECKSUM_EN
        , .chk (a_chk)
`endif
    );

    instr_encoder #(.DEPTH(4), .AW(2)) dut_b (
        .clk (clk), .rst_n (rst_n), .start (start), .finish (finish),
        .in_valid (in_valid), .in_ready (b_in_ready),
        .op_sel (op_sel), .rs (rs), .rt (rt), .rd (rd), .shamt (shamt), .imm (imm),
        .wr_en (b_wr_en), .wr_addr (b_wr_addr), .wr_data (b_wr_data),
        .count (b_count), .busy (b_busy), .done (b_done), .err_illegal (b_err)
`ifdef ENC_CHECKSUM_EN
        , .chk (b_chk)
`endif
    );

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  s;
        logic [4:0]  t;
        logic [4:0]  d;
        logic [4:0]  sh;
        logic [15:0] im;
        logic [31:0] exp;
    } vec_t;

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] o, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [4:0] sh, input logic [15:0] im);
        op_sel = o; rs = s; rt = t; rd = d; shamt = sh; imm = im;
        in_valid = 1'b1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; start = 1'b0; finish = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        step(); step();
        n_cmp++;
        if (a_all !== '0) begin n_err++; $display("FAIL reset_a: got %h want 0", a_all); end
        n_cmp++;
        if (b_all !== '0) begin n_err++; $display("FAIL reset_b: got %h want 0", b_all); end
`ifdef ENC_CHECKSUM_EN
        n_cmp++;
        if (a_chk !== 32'h0) begin n_err++; $display("FAIL reset_chk: got %h want 0", a_chk); end
`endif
        rst_n = 1'b1;
        step();
        // Fields offered in IDLE are neither accepted nor written.
        drive(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
        step();
        n_cmp++;
        if ({a_in_ready, a_wr_en, a_count, a_busy} !== {1'b0, 1'b0, 7'd0, 1'b0}) begin
            n_err++;
            $display("FAIL idle_ignore: got rdy=%b wr=%b cnt=%0d busy=%b want 0 0 0 0",
                     a_in_ready, a_wr_en, a_count, a_busy);
        end
        idle_inputs();
    endtask

    task automatic test_basic();
        pulse_start();
        n_cmp++;
        if ({a_busy, a_in_ready, a_done} !== 3'b110) begin
            n_err++; $display("FAIL start_state: got busy/rdy/done=%b want 110", {a_busy, a_in_ready, a_done});
        end
        drive(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
        step();
        idle_inputs();
        n_cmp++;
        if ({a_wr_en, a_wr_addr, a_wr_data, a_count} !== {1'b1, 6'd0, 32'h00221820, 7'd1}) begin
            n_err++; $display("FAIL add_write: got en=%b addr=%0d data=%h cnt=%0d want 1 0 00221820 1",
                              a_wr_en, a_wr_addr, a_wr_data, a_count);
        end
        step();
        n_cmp++;
        if ({a_wr_en, a_count} !== {1'b0, 7'd1}) begin
            n_err++; $display("FAIL add_hold: got en=%b cnt=%0d want 0 1", a_wr_en, a_count);
        end
    endtask

    task automatic test_back_to_back();
        pulse_start();
        drive(5'd15, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004);
        step();
        n_cmp++;
        if ({a_wr_en, a_wr_addr, a_wr_data, a_count} !== {1'b1, 6'd0, 32'h8FA80004, 7'd1}) begin
            n_err++; $display("FAIL b2b_lw: got en=%b addr=%0d data=%h cnt=%0d want 1 0 8fa80004 1",
                              a_wr_en, a_wr_addr, a_wr_data, a_count);
        end
        drive(5'd17, 5'd1, 5'd0, 5'd0, 5'd0, 16'hFFFF);
        step();
        idle_inputs();
        n_cmp++;
        if ({a_wr_en, a_wr_addr, a_wr_data, a_count} !== {1'b1, 6'd1, 32'h1020FFFF, 7'd2}) begin
            n_err++; $display("FAIL b2b_beq: got en=%b addr=%0d data=%h cnt=%0d want 1 1 1020ffff 2",
                              a_wr_en, a_wr_addr, a_wr_data, a_count);
        end
    endtask

    task automatic test_forcing();
        vec_t v[11];
        v[0]  = '{5'd8,  5'd7,  5'd1,  5'd2,  5'd4,  16'h0,    32'h00011100}; // sll, rs forced 0
        v[1]  = '{5'd13, 5'd31, 5'd3,  5'd5,  5'd9,  16'h0,    32'h03E00008}; // jr, rt/rd/shamt forced 0
        v[2]  = '{5'd0,  5'd1,  5'd2,  5'd3,  5'd5,  16'h0,    32'h00221820}; // add, shamt forced 0
        v[3]  = '{5'd1,  5'd4,  5'd5,  5'd6,  5'd0,  16'h0,    32'h00853022}; // sub
        v[4]  = '{5'd10, 5'd3,  5'd10, 5'd9,  5'd31, 16'h0,    32'h000A4FC3}; // sra shamt=31
        v[5]  = '{5'd7,  5'd2,  5'd3,  5'd1,  5'd0,  16'h0,    32'h0043082B}; // sltu
        v[6]  = '{5'd5,  5'd0,  5'd0,  5'd31, 5'd0,  16'h0,    32'h0000F827}; // nor
        v[7]  = '{5'd12, 5'd6,  5'd5,  5'd4,  5'd7,  16'h0,    32'h00C52006}; // srlv, shamt forced 0
        v[8]  = '{5'd14, 5'd1,  5'd2,  5'd9,  5'd9,  16'h8000, 32'h20228000}; // addi, rd/shamt ignored
        v[9]  = '{5'd16, 5'd29, 5'd31, 5'd0,  5'd0,  16'h0010, 32'hAFBF0010}; // sw
        v[10] = '{5'd18, 5'd3,  5'd4,  5'd0,  5'd0,  16'h0002, 32'h14640002}; // bne
        pulse_start();
        for (int i = 0; i < 11; i++) begin
            drive(v[i].op, v[i].s, v[i].t, v[i].d, v[i].sh, v[i].im);
            step();
            n_cmp++;
            if ({a_wr_en, a_wr_addr, a_wr_data, a_count} !== {1'b1, 6'(i), v[i].exp, 7'(i + 1)}) begin
                n_err++; $display("FAIL encode_%0d: got en=%b addr=%0d data=%h cnt=%0d want 1 %0d %h %0d",
                                  i, a_wr_en, a_wr_addr, a_wr_data, a_count, i, v[i].exp, i + 1);
            end
        end
        idle_inputs();
    endtask

    task automatic test_illegal();
        pulse_start();
        drive(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
        step();
        drive(5'd25, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
        step();
        n_cmp++;
        if ({a_wr_en, a_count, a_err} !== {1'b0, 7'd1, 1'b1}) begin
            n_err++; $display("FAIL illegal_25: got en=%b cnt=%0d err=%b want 0 1 1", a_wr_en, a_count, a_err);
        end
        drive(5'd19, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
        step();
        n_cmp++;
        if ({a_wr_en, a_count, a_err} !== {1'b0, 7'd1, 1'b1}) begin
            n_err++; $display("FAIL illegal_19: got en=%b cnt=%0d err=%b want 0 1 1", a_wr_en, a_count, a_err);
        end
        drive(5'd15, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004);
        step();
        idle_inputs();
        n_cmp++;
        if ({a_wr_en, a_wr_addr, a_wr_data, a_count, a_err} !== {1'b1, 6'd1, 32'h8FA80004, 7'd2, 1'b1}) begin
            n_err++; $display("FAIL illegal_next: got en=%b addr=%0d data=%h cnt=%0d err=%b want 1 1 8fa80004 2 1",
                              a_wr_en, a_wr_addr, a_wr_data, a_count, a_err);
        end
        pulse_start();
        n_cmp++;
        if ({a_err, a_count, a_done} !== {1'b0, 7'd0, 1'b0}) begin
            n_err++; $display("FAIL illegal_clear: got err=%b cnt=%0d done=%b want 0 0 0", a_err, a_count, a_done);
        end
    endtask

    task automatic test_full();
        pulse_start();
        for (int k = 0; k < 6; k++) begin
            drive(5'd0, 5'd1, 5'd2, 5'(k), 5'd0, 16'h0);
            step();
            if (k < 4) begin
                n_cmp++;
                if ({b_wr_en, b_wr_addr, b_wr_data, b_count} !==
                    {1'b1, 2'(k), 32'h00220020 | (32'(k) << 11), 3'(k + 1)}) begin
                    n_err++; $display("FAIL full_write_%0d: got en=%b addr=%0d data=%h cnt=%0d want 1 %0d %h %0d",
                                      k, b_wr_en, b_wr_addr, b_wr_data, b_count, k,
                                      32'h00220020 | (32'(k) << 11), k + 1);
                end
            end
            if (k == 3) begin
                n_cmp++;
                if ({b_in_ready, b_busy, b_done} !== 3'b010) begin
                    n_err++; $display("FAIL full_ready_drop: got rdy/busy/done=%b want 010", {b_in_ready, b_busy, b_done});
                end
            end
            if (k == 4) begin
                n_cmp++;
                if ({b_wr_en, b_done, b_busy, b_in_ready, b_count} !== {4'b0100, 3'd4}) begin
                    n_err++; $display("FAIL full_done: got en=%b done=%b busy=%b rdy=%b cnt=%0d want 0 1 0 0 4",
                                      b_wr_en, b_done, b_busy, b_in_ready, b_count);
                end
            end
            if (k == 5) begin
                n_cmp++;
                if ({b_wr_en, b_done, b_count} !== {2'b01, 3'd4}) begin
                    n_err++; $display("FAIL full_ignore: got en=%b done=%b cnt=%0d want 0 1 4", b_wr_en, b_done, b_count);
                end
            end
        end
        idle_inputs();
        pulse_start();
        n_cmp++;
        if ({b_done, b_count, b_in_ready, b_busy} !== {1'b0, 3'd0, 2'b11}) begin
            n_err++; $display("FAIL full_restart: got done=%b cnt=%0d rdy=%b busy=%b want 0 0 1 1",
                              b_done, b_count, b_in_ready, b_busy);
        end
    endtask

    task automatic test_finish();
        pulse_start();
        drive(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
        finish = 1'b1;
        step();
        finish = 1'b0;
        n_cmp++;
        if ({a_wr_en, a_wr_addr, a_wr_data, a_count, a_done, a_busy, a_in_ready} !==
            {1'b1, 6'd0, 32'h00221820, 7'd1, 3'b100}) begin
            n_err++; $display("FAIL finish_accept: got en=%b addr=%0d data=%h cnt=%0d done=%b busy=%b rdy=%b want 1 0 00221820 1 1 0 0",
                              a_wr_en, a_wr_addr, a_wr_data, a_count, a_done, a_busy, a_in_ready);
        end
        step();
        idle_inputs();
        n_cmp++;
        if ({a_wr_en, a_count, a_done} !== {1'b0, 7'd1, 1'b1}) begin
            n_err++; $display("FAIL finish_after: got en=%b cnt=%0d done=%b want 0 1 1", a_wr_en, a_count, a_done);
        end
    endtask

    task automatic test_restart();
        pulse_start();
        drive(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
        step();
        drive(5'd15, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004);
        start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++;
        if ({a_wr_en, a_wr_addr, a_count, a_busy} !== {1'b0, 6'd0, 7'd0, 1'b1}) begin
            n_err++; $display("FAIL restart_drop: got en=%b addr=%0d cnt=%0d busy=%b want 0 0 0 1",
                              a_wr_en, a_wr_addr, a_count, a_busy);
        end
        step();
        idle_inputs();
        n_cmp++;
        if ({a_wr_en, a_wr_addr, a_wr_data, a_count} !== {1'b1, 6'd0, 32'h8FA80004, 7'd1}) begin
            n_err++; $display("FAIL restart_write: got en=%b addr=%0d data=%h cnt=%0d want 1 0 8fa80004 1",
                              a_wr_en, a_wr_addr, a_wr_data, a_count);
        end
    endtask

`ifdef ENC_CHECKSUM_EN
    task automatic test_checksum();
        pulse_start();
        n_cmp++;
        if (a_chk !== 32'h0) begin n_err++; $display("FAIL chk_clear: got %h want 0", a_chk); end
        drive(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
        step();
        drive(5'd15, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004);
        step();
        idle_inputs();
        n_cmp++;
        if (a_chk !== 32'h8F8A1824) begin n_err++; $display("FAIL chk_value: got %h want 8f8a1824", a_chk); end
    endtask
`endif

    task automatic test_reset_mid();
        pulse_start();
        drive(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
        step();
        drive(5'd15, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (a_all !== '0) begin n_err++; $display("FAIL midreset_a: got %h want 0", a_all); end
        n_cmp++;
        if (b_all !== '0) begin n_err++; $display("FAIL midreset_b: got %h want 0", b_all); end
`ifdef ENC_CHECKSUM_EN
        n_cmp++;
        if (a_chk !== 32'h0) begin n_err++; $display("FAIL midreset_chk: got %h want 0", a_chk); end
`endif
        step();
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (a_all !== '0) begin n_err++; $display("FAIL midreset_after: got %h want 0", a_all); end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_forcing();
        test_illegal();
        test_full();
        test_finish();
        test_restart();
`ifdef ENC_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
